// File: rtl/multi_ce_gen.sv
// rtl/multi_ce_gen.sv - multi-channel NCO clock-enable / divided-waveform generator
// Shadow/active programming with global apply and a lock status.
module multi_ce_gen #(
  parameter  int NUM_CH      = 3,
  parameter  int ACC_W       = 16,
  parameter  int LOCK_CYCLES = 64,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] wave,
  output logic              locked,
  output logic              cfg_pending
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0]   LOCK_SAT  = LCW'(LOCK_CYCLES);
  localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);
  localparam logic [ACC_W-1:0] DUTY_RST  = {1'b1, {(ACC_W - 1){1'b0}}};

  localparam logic [1:0] SEL_INCR  = 2'd0;
  localparam logic [1:0] SEL_PHASE = 2'd1;
  localparam logic [1:0] SEL_DUTY  = 2'd2;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  logic [ACC_W-1:0] incr_sh  [NUM_CH];
  logic [ACC_W-1:0] phase_sh [NUM_CH];
  logic [ACC_W-1:0] duty_sh  [NUM_CH];
  logic [ACC_W-1:0] incr_act [NUM_CH];
  logic [ACC_W-1:0] duty_act [NUM_CH];
  logic [ACC_W-1:0] acc      [NUM_CH];
  logic [ACC_W:0]   acc_sum  [NUM_CH];

  logic              wr_ok;
  logic [NUM_CH-1:0] wr_hit;

  lock_state_t    state, state_nx;
  logic [LCW-1:0] lock_cnt, lock_cnt_nx;

  // Out-of-range channels and the reserved selector are silently dropped.
  assign wr_ok = cfg_wr && ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_sel != 2'd3);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
      acc_sum[i] = {1'b0, acc[i]} + {1'b0, incr_act[i]};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        incr_sh[i]  <= '0;
        phase_sh[i] <= '0;
        duty_sh[i]  <= DUTY_RST;
        incr_act[i] <= '0;
        duty_act[i] <= DUTY_RST;
        acc[i]      <= '0;
      end
      ce   <= '0;
      wave <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Apply reads the shadows before any same-cycle write lands in them.
        if (cfg_apply) begin
          incr_act[i] <= incr_sh[i];
          duty_act[i] <= duty_sh[i];
          acc[i]      <= phase_sh[i];
          ce[i]       <= 1'b0;
          wave[i]     <= (phase_sh[i] < duty_sh[i]);
        end else begin
          acc[i]  <= acc_sum[i][ACC_W-1:0];
          ce[i]   <= acc_sum[i][ACC_W];
          wave[i] <= (acc_sum[i][ACC_W-1:0] < duty_act[i]);
        end

        if (wr_hit[i]) begin
          case (cfg_sel)
            SEL_INCR:  incr_sh[i]  <= cfg_data;
            SEL_PHASE: phase_sh[i] <= cfg_data;
            SEL_DUTY:  duty_sh[i]  <= cfg_data;
            default:   ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pending <= 1'b0;
    end else if (cfg_apply) begin
      cfg_pending <= wr_ok;
    end else if (wr_ok) begin
      cfg_pending <= 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_cnt_nx;
    end
  end

  // Counter saturates so a stalled UNLOCKED state can never wrap back to zero.
  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    case (state)
      UNLOCKED: begin
        if (lock_cnt != LOCK_SAT) begin
          lock_cnt_nx = lock_cnt + 1'b1;
        end
        if (lock_cnt == LOCK_LAST) begin
          state_nx = LOCKED;
        end
      end
      LOCKED:  ;
      default: state_nx = UNLOCKED;
    endcase
    if (cfg_apply) begin
      state_nx    = UNLOCKED;
      lock_cnt_nx = '0;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_multi_ce_gen.sv
// tb/tb_multi_ce_gen.sv - randomized self-checking bench for multi_ce_gen
module tb_multi_ce_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 64;
  localparam int CH_W        = 2;
  localparam longint MODV    = longint'(1) << ACC_W;

  logic              refclk;
  logic              rst_n;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_sel;
  logic [ACC_W-1:0]  cfg_data;
  logic              cfg_apply;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] wave;
  logic              locked;
  logic              cfg_pending;

  multi_ce_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .cfg_apply  (cfg_apply),
    .ce         (ce),
    .wave       (wave),
    .locked     (locked),
    .cfg_pending(cfg_pending)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: channel programming as plain numbers, output timing from arithmetic.
  longint m_incr_sh  [NUM_CH];
  longint m_phase_sh [NUM_CH];
  longint m_duty_sh  [NUM_CH];
  longint m_incr     [NUM_CH];
  longint m_duty     [NUM_CH];
  longint m_acc      [NUM_CH];
  bit     m_ce       [NUM_CH];
  bit     m_wave     [NUM_CH];
  int     m_since;
  bit     m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_incr_sh[c]  = 0;
      m_phase_sh[c] = 0;
      m_duty_sh[c]  = MODV / 2;
      m_incr[c]     = 0;
      m_duty[c]     = MODV / 2;
      m_acc[c]      = 0;
      m_ce[c]       = 0;
      m_wave[c]     = 0;
    end
    m_since = 0;
    m_pend  = 0;
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] exp_ce;
    logic [NUM_CH-1:0] exp_wave;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_ce[c]   = m_ce[c];
      exp_wave[c] = m_wave[c];
    end
    check("ce", 32'(ce), 32'(exp_ce));
    check("wave", 32'(wave), 32'(exp_wave));
    check("locked", 32'(locked), 32'(m_since >= LOCK_CYCLES));
    check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check at next fall.
  task automatic step(input bit wr, input int ch, input int sel, input longint data, input bit ap);
    bit     wr_ok;
    longint s;
    cfg_wr    = wr;
    cfg_ch    = CH_W'(ch);
    cfg_sel   = 2'(sel);
    cfg_data  = ACC_W'(data);
    cfg_apply = ap;
    wr_ok = wr && (ch < NUM_CH) && (sel != 3);
    if (ap) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_incr[c] = m_incr_sh[c];
        m_duty[c] = m_duty_sh[c];
        m_acc[c]  = m_phase_sh[c];
        m_ce[c]   = 0;
        m_wave[c] = (m_phase_sh[c] < m_duty_sh[c]);
      end
      m_since = 0;
      m_pend  = wr_ok;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        s = m_acc[c] + m_incr[c];
        m_ce[c]   = (s >= MODV);
        m_acc[c]  = s % MODV;
        m_wave[c] = (m_acc[c] < m_duty[c]);
      end
      if (m_since < LOCK_CYCLES) m_since++;
      if (wr_ok) m_pend = 1;
    end
    if (wr_ok) begin
      case (sel)
        0:       m_incr_sh[ch]  = data % MODV;
        1:       m_phase_sh[ch] = data % MODV;
        default: m_duty_sh[ch]  = data % MODV;
      endcase
    end
    @(posedge refclk);
    @(negedge refclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    #2;
    rst_n     = 1'b0;
    cfg_wr    = 1'b0;
    cfg_apply = 1'b0;
    #1;
    check("async_ce", 32'(ce), 32'd0);
    check("async_wave", 32'(wave), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    model_reset();
    @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_wr    = 1'b0;
    cfg_ch    = '0;
    cfg_sel   = '0;
    cfg_data  = '0;
    cfg_apply = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    check_outputs();

    idle(LOCK_CYCLES + 6);

    step(1, 0, 0, 64, 0);
    step(0, 0, 0, 0, 1);
    idle(LOCK_CYCLES + 10);

    step(1, 1, 0, 64, 0);
    step(1, 1, 1, 128, 0);
    step(1, 2, 2, 64, 0);
    step(0, 0, 0, 0, 1);
    idle(LOCK_CYCLES + 4);

    step(1, 2, 0, 32, 0);
    idle(6);
    step(0, 0, 0, 0, 1);
    idle(12);

    step(1, 0, 0, 128, 1);
    idle(8);
    step(0, 0, 0, 0, 1);
    idle(8);

    step(1, 3, 0, 5, 0);
    step(1, 0, 3, 5, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(4);

    mid_reset();
    idle(LOCK_CYCLES + 4);

    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) mid_reset();
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           longint'($urandom), ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
